// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: time-multiplexed 4-digit hex seven-segment driver.
// A refresh prescaler divides each digit slot into CLK_DIV cycles. A 2-bit
// scan index walks digits 0..3. A per-frame snapshot of the display register
// prevents tearing. The first BLANK_CYCLES of every slot keep all digit enables
// off to hide ghosting.
// Optional build macro: SEVEN_SEG_LEADING_ZERO_BLANK_EN suppresses leading
// zero digits (3..1) based on the snapshot.
module seven_seg_scanner #(
  parameter int CLK_DIV        = 1024,
  parameter int BLANK_CYCLES   = 16,
  parameter int INPUT_INVERTED = 1,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] display_in,
  input  logic        blank,
  input  logic [3:0]  dp_mask,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic [3:0]  digit_sel_n,
  output logic        frame_start
);

  localparam int PW = $clog2(CLK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PRE_PEN  = PW'(CLK_DIV - 2);
  localparam logic [PW:0]   BLANK_W  = (PW+1)'(BLANK_CYCLES);

  // Pin levels that mean "off" for the chosen polarity.
  localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic       DP_OFF  = (SEG_ACTIVE_LOW != 0) ? 1'b1  : 1'b0;
  localparam logic [3:0] SEL_OFF = (SEG_ACTIVE_LOW != 0) ? 4'hF  : 4'h0;

  logic [PW-1:0] prescaler;
  logic [1:0]    digit_idx;
  logic [15:0]   snapshot;

  logic [3:0] nibble;
  logic [6:0] seg_hi;
  logic       dp_hi;
  logic [3:0] sel_hi;
  logic       digit_on;
  logic       suppress;
  logic       frame_next;

  // Hex digit to active-high gfedcba segment pattern.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    case (v)
      4'h0: return 7'h3F;
      4'h1: return 7'h06;
      4'h2: return 7'h5B;
      4'h3: return 7'h4F;
      4'h4: return 7'h66;
      4'h5: return 7'h6D;
      4'h6: return 7'h7D;
      4'h7: return 7'h07;
      4'h8: return 7'h7F;
      4'h9: return 7'h6F;
      4'hA: return 7'h77;
      4'hB: return 7'h7C;
      4'hC: return 7'h39;
      4'hD: return 7'h5E;
      4'hE: return 7'h79;
      default: return 7'h71;
    endcase
  endfunction

  // Prescaler, scan index and per-frame snapshot of the display register.
  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler <= '0;
      digit_idx <= 2'd0;
      snapshot  <= 16'h0000;
    end else if (prescaler == PRE_LAST) begin
      prescaler <= '0;
      digit_idx <= digit_idx + 2'd1;
      if (digit_idx == 2'd3) begin
        snapshot <= (INPUT_INVERTED != 0) ? ~display_in : display_in;
      end
    end else begin
      prescaler <= prescaler + PW'(1);
    end
  end

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
  // Hide a digit when it and every more significant nibble are zero; digit 0 always shows.
  always_comb begin
    suppress = 1'b0;
    case (digit_idx)
      2'd3: suppress = (snapshot[15:12] == 4'h0);
      2'd2: suppress = (snapshot[15:8]  == 8'h00);
      2'd1: suppress = (snapshot[15:4]  == 12'h000);
      default: suppress = 1'b0;
    endcase
  end
`else
  assign suppress = 1'b0;
`endif

  // Next output values, active-high, derived from the current scan state.
  always_comb begin
    nibble   = snapshot[{digit_idx, 2'b00} +: 4];
    seg_hi   = hex_to_seg(nibble);
    dp_hi    = dp_mask[digit_idx];
    digit_on = ({1'b0, prescaler} >= BLANK_W) && !blank && !suppress;
    sel_hi   = digit_on ? (4'b0001 << digit_idx) : 4'b0000;
    // Looks one cycle ahead so the registered pulse lands in the cycle
    // whose closing edge loads the new snapshot.
    frame_next = (prescaler == PRE_PEN) && (digit_idx == 2'd3);
  end

  // Registered pin drive with polarity applied; reset forces everything off.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_n       <= SEG_OFF;
      dp_n        <= DP_OFF;
      digit_sel_n <= SEL_OFF;
      frame_start <= 1'b0;
    end else begin
      seg_n       <= (SEG_ACTIVE_LOW != 0) ? ~seg_hi : seg_hi;
      dp_n        <= (SEG_ACTIVE_LOW != 0) ? ~dp_hi  : dp_hi;
      digit_sel_n <= (SEG_ACTIVE_LOW != 0) ? ~sel_hi : sel_hi;
      frame_start <= frame_next;
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner with CLK_DIV=4, BLANK_CYCLES=1, inverted input,
// active-low pins. The reference model works from absolute cycle count since
// reset: slot = t/4, digit = slot%4, frame = t/16.
module tb_seven_seg_scanner;

  logic        clk;
  logic        rst;
  logic [15:0] display_in;
  logic        blank;
  logic [3:0]  dp_mask;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [3:0]  digit_sel_n;
  logic        frame_start;

  int n_tests = 0;
  int n_fail  = 0;

  seven_seg_scanner #(
    .CLK_DIV(4), .BLANK_CYCLES(1), .INPUT_INVERTED(1), .SEG_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst(rst), .display_in(display_in), .blank(blank),
    .dp_mask(dp_mask), .seg_n(seg_n), .dp_n(dp_n),
    .digit_sel_n(digit_sel_n), .frame_start(frame_start)
  );

  // Clock and watchdog.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  logic [12:0] obs;
  assign obs = {digit_sel_n, seg_n, dp_n, frame_start};

  // Reference model.
  logic [6:0] seg_ref [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  int          t;
  int          md;
  int          mph;
  logic [15:0] m_val;
  logic [15:0] exp_val;
  logic [12:0] exp_out;

  function automatic logic supp(input logic [15:0] v, input int d);
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    return (d > 0) && ((v >> (4 * d)) == 16'h0000);
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      t       <= 0;
      m_val   <= 16'h0000;
      exp_val <= 16'h0000;
      exp_out <= {4'hF, 7'h7F, 1'b1, 1'b0};
    end else begin
      md  = (t / 4) % 4;
      mph = t % 4;
      exp_out <= {((mph >= 1) && !blank && !supp(m_val, md)) ? ~(4'b0001 << md) : 4'hF,
                  ~seg_ref[m_val[4*md +: 4]], ~dp_mask[md], ((t + 1) % 16 == 15)};
      exp_val <= m_val;
      if (t % 16 == 15) m_val <= ~display_in;
      t <= t + 1;
    end
  end

  // Reset hold, first frame shows zeros, first frame_start 15 cycles after release.
  task automatic test_reset();
    int first_fs;
    rst = 1'b1; blank = 1'b0; dp_mask = 4'h0; display_in = 16'hEDCB;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_tests++;
      if (obs !== 13'({4'hF, 7'h7F, 1'b1, 1'b0})) begin
        n_fail++; $display("FAIL reset_hold: got %h want %h", obs, 13'({4'hF, 7'h7F, 1'b1, 1'b0}));
      end
    end
    rst = 1'b0;
    first_fs = -1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      n_tests++;
      if (obs !== exp_out) begin
        n_fail++; $display("FAIL reset_model c=%0d: got %h want %h", c, obs, exp_out);
      end
      n_tests++;
      if (seg_n !== 7'h40) begin
        n_fail++; $display("FAIL reset_zero_seg c=%0d: got %h want 40", c, seg_n);
      end
      if (frame_start === 1'b1 && first_fs < 0) first_fs = c;
    end
    n_tests++;
    if (first_fs != 15) begin
      n_fail++; $display("FAIL first_frame_start: got %0d want 15", first_fs);
    end
  endtask

  // Second frame shows 0x1234: digit walk E,D,B,7 with one blank cycle per slot.
  task automatic test_basic_scan();
    logic [3:0] sel_tab [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic [6:0] seg_tab [4] = '{7'h19, 7'h30, 7'h24, 7'h79};
    int k;
    for (int c = 17; c <= 32; c++) begin
      @(negedge clk);
      k = c - 17;
      n_tests++;
      if (obs !== exp_out) begin
        n_fail++; $display("FAIL basic_model c=%0d: got %h want %h", c, obs, exp_out);
      end
      n_tests++;
      if (digit_sel_n !== ((k % 4 == 0) ? 4'hF : sel_tab[k / 4]) || seg_n !== seg_tab[k / 4]) begin
        n_fail++;
        $display("FAIL basic_scan c=%0d: got sel %h seg %h want sel %h seg %h", c, digit_sel_n, seg_n,
                 (k % 4 == 0) ? 4'hF : sel_tab[k / 4], seg_tab[k / 4]);
      end
    end
  endtask

  // Input changed mid-frame must not reach the display before the next frame.
  task automatic test_anti_tear();
    logic [6:0] seg_tab [4] = '{7'h19, 7'h30, 7'h24, 7'h79};
    logic [6:0] want;
    for (int c = 33; c <= 64; c++) begin
      @(negedge clk);
      want = (c <= 48) ? seg_tab[(c - 33) / 4] : 7'h0E;
      n_tests++;
      if (obs !== exp_out) begin
        n_fail++; $display("FAIL tear_model c=%0d: got %h want %h", c, obs, exp_out);
      end
      n_tests++;
      if (seg_n !== want) begin
        n_fail++; $display("FAIL anti_tear_seg c=%0d: got %h want %h", c, seg_n, want);
      end
      n_tests++;
      if (frame_start !== ((c == 47) || (c == 63))) begin
        n_fail++; $display("FAIL tear_frame_start c=%0d: got %b want %b", c, frame_start, (c == 47) || (c == 63));
      end
      if (c == 37) display_in = 16'h0000;
    end
  endtask

  // dp only in digit 2; blank forces digits off while frames keep ticking.
  task automatic test_blank_dp();
    logic bl_sampled;
    int   fs_count;
    bl_sampled = 1'b0;
    fs_count = 0;
    dp_mask = 4'b0100;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      n_tests++;
      if (obs !== exp_out) begin
        n_fail++; $display("FAIL blank_model i=%0d: got %h want %h", i, obs, exp_out);
      end
      if (bl_sampled) begin
        n_tests++;
        if (digit_sel_n !== 4'hF) begin
          n_fail++; $display("FAIL blank_off i=%0d: got %h want f", i, digit_sel_n);
        end
      end
      if (i > 0 && digit_sel_n !== 4'hF) begin
        n_tests++;
        if (dp_n !== (digit_sel_n != 4'hB)) begin
          n_fail++; $display("FAIL dp_digit2 i=%0d: got %b want %b", i, dp_n, digit_sel_n != 4'hB);
        end
      end
      if (frame_start === 1'b1) fs_count++;
      display_in = 16'($urandom);
      blank = (i >= 20 && i < 40);
      bl_sampled = blank;
    end
    blank = 1'b0;
    n_tests++;
    if (fs_count != 4) begin
      n_fail++; $display("FAIL blank_frame_count: got %0d want 4", fs_count);
    end
  endtask

  // Randomised inputs against the model.
  task automatic test_random();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      n_tests++;
      if (obs !== exp_out) begin
        n_fail++; $display("FAIL random_model i=%0d: got %h want %h", i, obs, exp_out);
      end
      if ($urandom_range(0, 3) == 0) display_in = 16'($urandom);
      if ($urandom_range(0, 7) == 0) dp_mask = 4'($urandom);
      blank = ($urandom_range(0, 5) == 0);
    end
    blank = 1'b0;
  endtask

  // Reset while digit 2 is lit: all off next cycle, rescan from digit 0 showing zeros.
  task automatic test_reset_mid();
    logic found;
    found = 1'b0;
    display_in = 16'h5A5A;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (digit_sel_n === 4'hB) found = 1'b1;
    end
    n_tests++;
    if (!found) begin
      n_fail++; $display("FAIL reset_mid_wait: got no digit2 want digit2 within 20");
    end
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if (obs !== 13'({4'hF, 7'h7F, 1'b1, 1'b0})) begin
      n_fail++; $display("FAIL reset_mid_off: got %h want %h", obs, 13'({4'hF, 7'h7F, 1'b1, 1'b0}));
    end
    rst = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      n_tests++;
      if (obs !== exp_out) begin
        n_fail++; $display("FAIL reset_mid_model c=%0d: got %h want %h", c, obs, exp_out);
      end
      n_tests++;
      if (seg_n !== 7'h40) begin
        n_fail++; $display("FAIL reset_mid_zero c=%0d: got %h want 40", c, seg_n);
      end
      if (c == 2) begin
        n_tests++;
        if (digit_sel_n !== 4'hE) begin
          n_fail++; $display("FAIL reset_mid_digit0: got %h want e", digit_sel_n);
        end
      end
    end
  endtask

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
  // 0x0040 shows "40": digits 3 and 2 dark.
  task automatic test_leading_zero();
    int seen0;
    int seen1;
    seen0 = 0;
    seen1 = 0;
    blank = 1'b0;
    display_in = ~16'h0040;
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      n_tests++;
      if (obs !== exp_out) begin
        n_fail++; $display("FAIL lz_model i=%0d: got %h want %h", i, obs, exp_out);
      end
      if (exp_val == 16'h0040) begin
        n_tests++;
        if (digit_sel_n[3] !== 1'b1 || digit_sel_n[2] !== 1'b1) begin
          n_fail++; $display("FAIL lz_hidden i=%0d: got %h want bits3,2 high", i, digit_sel_n);
        end
        if (digit_sel_n === 4'hD) begin
          seen1++;
          n_tests++;
          if (seg_n !== 7'h19) begin
            n_fail++; $display("FAIL lz_digit1: got %h want 19", seg_n);
          end
        end
        if (digit_sel_n === 4'hE) begin
          seen0++;
          n_tests++;
          if (seg_n !== 7'h40) begin
            n_fail++; $display("FAIL lz_digit0: got %h want 40", seg_n);
          end
        end
      end
    end
    n_tests++;
    if (seen0 == 0 || seen1 == 0) begin
      n_fail++; $display("FAIL lz_seen: got d0=%0d d1=%0d want both nonzero", seen0, seen1);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_scan();
    test_anti_tear();
    test_blank_dp();
    test_random();
    test_reset_mid();
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    test_leading_zero();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
